// File: rtl/store_merge_unit_if.sv
// store_merge_unit_if: store request + word memory port bundle.
// slave = merge unit; master = pipeline/memory side.
interface store_merge_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;
  logic        busy;

  modport slave (
    input  req_valid, req_addr, req_data, req_size,
    input  mem_rdata, mem_rvalid,
    output req_ready, mem_addr, mem_rd_en,
    output mem_wr_en, mem_wdata, done, err, busy
  );

  modport master (
    output req_valid, req_addr, req_data, req_size,
    output mem_rdata, mem_rvalid,
    input  req_ready, mem_addr, mem_rd_en,
    input  mem_wr_en, mem_wdata, done, err, busy
  );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit: byte/half/word store merge into word memory (RMW).
// Ports: clk, rst (sync, high), bus (slave). Option: MISALIGN_TRAP_EN.
module store_merge_unit (
  input logic              clk,
  input logic              rst,
  store_merge_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, WRITE, ERR
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;
  logic [15:0] dat_q;

  logic        rdy_q;
  logic        busy_q;
  logic        rd_q;
  logic        wr_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        mis;
  logic        bad;
  logic        is_byte;
  logic        is_half;
  logic [31:0] merged;

`ifdef MISALIGN_TRAP_EN
  assign mis =
    (bus.req_size == 2'b01 && bus.req_addr[0]) ||
    (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign bad = (bus.req_size == 2'b11) || mis;

  assign is_byte = (size_q == 2'b00);
  assign is_half = (size_q == 2'b01);

  // Replace only the addressed lane(s) of the fetched word.
  always_comb begin
    merged = bus.mem_rdata;
    unique case (1'b1)
      is_byte: merged[{lo_q, 3'b000} +: 8] = dat_q[7:0];
      is_half: merged[{lo_q[1], 4'b0000} +: 16] = dat_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      size_q  <= 2'b00;
      lo_q    <= 2'b00;
      dat_q   <= 16'h0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            size_q <= bus.req_size;
            lo_q   <= bus.req_addr[1:0];
            dat_q  <= bus.req_data[15:0];
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bad) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              addr_q <= {bus.req_addr[31:2], 2'b00};
              if (bus.req_size == 2'b10) begin
                state   <= WRITE;
                wr_q    <= 1'b1;
                done_q  <= 1'b1;
                wdata_q <= bus.req_data;
              end else begin
                state <= READ;
                rd_q  <= 1'b1;
              end
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          if (bus.mem_rvalid) begin
            state   <= WRITE;
            wr_q    <= 1'b1;
            done_q  <= 1'b1;
            wdata_q <= merged;
          end
        end
        WRITE, ERR: begin
          state  <= IDLE;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.mem_rd_en = rd_q;
  assign bus.mem_wr_en = wr_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed stores, scoreboard-checked.
// Expected strobes/cycles queued at issue; monitor pops on outputs.
module tb_store_merge_unit;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ERR = 2;
  localparam int K_RDY = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  logic prev_rdy = 1'b1;
  exp_t sb[$];

  logic [31:0] mem_word = 32'h0;
  int          mem_lat = 1;

  store_merge_unit_if bus ();

  store_merge_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input int c,
                      input logic [31:0] a,
                      input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic take(input int k, input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got event at cyc %0d want none",
               nm, cyc);
    end else begin
      e = sb.pop_front();
      chk({nm, "_kind"}, k, e.kind);
      chk({nm, "_cyc"}, cyc, e.cyc);
      if (k == K_RD || k == K_WR)
        chk({nm, "_addr"}, bus.mem_addr, e.addr);
      if (k == K_WR)
        chk({nm, "_wdata"}, bus.mem_wdata, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.mem_rd_en) take(K_RD, "rd");
      if (bus.mem_wr_en) take(K_WR, "wr");
      if (bus.err) take(K_ERR, "err");
      if (bus.req_ready && prev_rdy === 1'b0)
        take(K_RDY, "rdy");
      chk("done_vs_wr", bus.done, bus.mem_wr_en);
      chk("ready_vs_busy", bus.req_ready, !bus.busy);
    end
    prev_rdy = bus.req_ready;
  end

  // Word memory: answers each read after mem_lat cycles.
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_en === 1'b1) begin
        repeat (mem_lat) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_word;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hBAD0BAD0;
      end
    end
  end

  task automatic wait_idle;
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", bus.req_ready, 1'b1);
  endtask

  // kind: 0 word, 1 sub-word, 2 rejected
  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0]  s,
                       input logic [31:0] mw,
                       input int          lat,
                       input int          kind,
                       input logic [31:0] ew);
    int c;
    wait_idle();
    mem_word = mw;
    mem_lat  = lat;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
    bus.req_valid = 1'b1;
    c = cyc;
    if (kind == 0) begin
      push(K_WR, c + 1, {a[31:2], 2'b00}, ew);
      push(K_RDY, c + 2, 32'h0, 32'h0);
    end else if (kind == 1) begin
      push(K_RD, c + 1, {a[31:2], 2'b00}, 32'h0);
      push(K_WR, c + 2 + lat, {a[31:2], 2'b00}, ew);
      push(K_RDY, c + 3 + lat, 32'h0, 32'h0);
    end else begin
      push(K_ERR, c + 1, 32'h0, 32'h0);
      push(K_RDY, c + 2, 32'h0, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_data  = 32'h5555_5555;
    bus.req_size  = 2'b11;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_rd"}, bus.mem_rd_en, 1'b0);
    chk({tag, "_wr"}, bus.mem_wr_en, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_err"}, bus.err, 1'b0);
    chk({tag, "_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_data  = 32'h0;
    bus.req_size  = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst0");
    rst = 1'b0;
    mon_on = 1'b1;

    store(32'h100, 32'hDEADBEEF, 2'b10, 32'h0, 1, 0, 32'hDEADBEEF);
    store(32'h102, 32'h123456AB, 2'b00, 32'h11223344, 1, 1,
          32'h11AB3344);
    store(32'h202, 32'h0000CAFE, 2'b01, 32'hAAAABBBB, 3, 1,
          32'hCAFEBBBB);
`ifdef MISALIGN_TRAP_EN
    store(32'h101, 32'h0000BEEF, 2'b01, 32'h55667788, 1, 2, 32'h0);
    store(32'h106, 32'h01020304, 2'b10, 32'h0, 1, 2, 32'h0);
`else
    store(32'h101, 32'h0000BEEF, 2'b01, 32'h55667788, 1, 1,
          32'h5566BEEF);
    store(32'h106, 32'h01020304, 2'b10, 32'h0, 1, 0, 32'h01020304);
`endif
    store(32'h104, 32'h0BADF00D, 2'b11, 32'h0, 1, 2, 32'h0);
    store(32'h103, 32'h00000077, 2'b00, 32'h11223344, 2, 1,
          32'h77223344);
    store(32'h100, 32'hFFFFFF5A, 2'b00, 32'h11223344, 1, 1,
          32'h1122335A);
    store(32'h101, 32'h000000C3, 2'b00, 32'h00000000, 1, 1,
          32'h0000C300);
    store(32'h300, 32'h1234ABCD, 2'b01, 32'hFFFFFFFF, 1, 1,
          32'hFFFFABCD);
    store(32'h108, 32'hCAFEF00D, 2'b10, 32'h0, 1, 0, 32'hCAFEF00D);
    store(32'h10C, 32'h76543210, 2'b10, 32'h0, 1, 0, 32'h76543210);

    // Reset while waiting for read data; the late rvalid is ignored.
    wait_idle();
    mem_word = 32'h12345678;
    mem_lat  = 5;
    bus.req_addr  = 32'h10C;
    bus.req_data  = 32'h00000099;
    bus.req_size  = 2'b00;
    bus.req_valid = 1'b1;
    c = cyc;
    push(K_RD, c + 1, 32'h10C, 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(K_RDY, c + 3, 32'h0, 32'h0);
    @(negedge clk);
    chk_reset_outs("rst_mid");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    store(32'h10E, 32'h00004321, 2'b01, 32'h12345678, 1, 1,
          32'h43215678);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-path counterpart to the load-side sign extender in the MIPS CPU datapath. It narrows a 32-bit register value to a byte, halfword or word store and merges it into a word-only data memory. Sub-word stores use a read-modify-write sequence. It sits between the MEM-stage store request and the data memory port, and reports completion or an address error back to the pipeline.

## Interface
- No parameters; all widths are fixed at 32-bit data and address.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept a request
- req_addr  in  32  byte address of the store
- req_data  in  32  register value; only the low 8/16/32 bits are stored
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- mem_addr  out  32  word-aligned memory address; bits [1:0] are always 0
- mem_rd_en  out  1  one-cycle read strobe
- mem_rdata  in  32  read data, qualified by mem_rvalid
- mem_rvalid  in  1  read data valid; any latency of 1 cycle or more
- mem_wr_en  out  1  one-cycle write strobe
- mem_wdata  out  32  merged write word
- done  out  1  one-cycle pulse when the store is committed
- err  out  1  one-cycle pulse when the store is rejected
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, READ, WAIT, WRITE, ERR.
- **Accept:** a request is accepted when req_valid && req_ready. On accept, addr, data and size are latched; later req_* changes are ignored.
- **Byte lanes:** little-endian.
  - Byte at addr[1:0]=n uses bits [8n+7:8n].
  - Halfword at addr[1]=h uses bits [16h+15:16h].
- **Word store:** IDLE -> WRITE -> IDLE. No read is issued; mem_wdata = data.
- **Byte/half store:** IDLE -> READ -> WAIT -> WRITE -> IDLE.
  - READ drives mem_rd_en for exactly one cycle.
  - WAIT holds until mem_rvalid, then captures mem_rdata.
  - WRITE drives mem_wdata = captured word with only the target lane(s) replaced by data[7:0] or data[15:0].
- **Error:** IDLE -> ERR -> IDLE for size 11, or for a misaligned address when the macro is enabled (see Configuration). No memory strobe is issued.
- **Outputs per state:**
  - WRITE: mem_wr_en=1 and done=1 in the same cycle.
  - ERR: err=1.
  - req_ready=1 only in IDLE.
- mem_rvalid outside WAIT is ignored.
- mem_addr = {addr[31:2],2'b00}, held stable from READ through WRITE.
- **Reset:** every output is 0 except req_ready=1 (state IDLE) after the first clk edge with rst high.
  - Reset mid-operation aborts the store: no write, no done, no err.
  - A late mem_rvalid arriving after reset is ignored.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from req_* or mem_* to any output.
- Word store accepted in cycle 0: mem_wr_en/done in cycle 1; req_ready high again in cycle 2.
- Sub-word store accepted in cycle 0:
  - mem_rd_en in cycle 1.
  - WAIT from cycle 2.
  - mem_rvalid in cycle k (k≥2) gives mem_wr_en/done in cycle k+1 and req_ready in cycle k+2.
- Error accepted in cycle 0: err in cycle 1; req_ready in cycle 2.
- Back-to-back throughput:
  - one word store per 2 cycles;
  - one sub-word store per 4 cycles with 1-cycle memory latency.

## Configuration
- MISALIGN_TRAP_EN defined:
  - a halfword with addr[0]=1, or a word with addr[1:0]≠0, takes the ERR path;
  - err pulses and memory is untouched.
- MISALIGN_TRAP_EN undefined:
  - misaligned low bits are silently dropped: halfword uses addr[1] only, word ignores addr[1:0];
  - the store completes normally with done;
  - err occurs only for size 11.

## Test plan
- Word store, addr=0x100, data=0xDEADBEEF -> mem_wr_en cycle 1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done cycle 1, mem_rd_en never asserted.
- Byte store, addr=0x102, data=0x123456AB, memory word 0x11223344, rvalid 1 cycle after read -> mem_rd_en cycle 1, mem_wdata=0x11AB3344 with done in cycle 3.
- Halfword store, addr=0x202, data=0x0000CAFE, memory word 0xAAAABBBB, rvalid delayed 3 cycles -> mem_wdata=0xCAFEBBBB; req_ready low throughout.
- Halfword store, addr=0x101:
  - with MISALIGN_TRAP_EN -> err in cycle 1, no mem strobe;
  - without it -> behaves as addr=0x100, done asserted.
- req_size=11 -> err pulse in cycle 1, no mem strobe, req_ready in cycle 2.
- Reset asserted in WAIT, then mem_rvalid after reset -> no mem_wr_en, no done, all outputs at reset values, next request serviced normally.
